// File: rtl/dmem_sized.sv
// Sized, byte-addressed 64-bit data memory with registered loads, lane-masked stores
// and misaligned/out-of-range rejection. Define DMEM_CLEAR_EN to zero-sweep the array after reset.
module dmem_sized #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              w,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] adr,
  input  logic [63:0]       datain,
  output logic              ready,
  output logic              rvalid,
  output logic [63:0]       dataout,
  output logic              err
);

  localparam int unsigned IW  = $clog2(DEPTH);
  localparam int unsigned TOP = IW + 3;

  logic [63:0]   mem [DEPTH];

  logic [IW-1:0] idx;
  logic [2:0]    off;
  logic          oor;
  logic          mis;
  logic          bad;
  logic          acc;

  logic [7:0]    be_base;
  logic [7:0]    st_be;
  logic [63:0]   st_wd;
  logic [63:0]   rword;
  logic [63:0]   lsh;
  logic [63:0]   ld_ext;

  logic          mem_we;
  logic [IW-1:0] mem_idx;
  logic [7:0]    mem_be;
  logic [63:0]   mem_wd;

`ifdef DMEM_CLEAR_EN
  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
`endif

  assign idx = adr[TOP-1:3];
  assign off = adr[2:0];

  // Address bits above the array span must all be zero.
  if (ADDR_W > TOP) begin : g_oor
    assign oor = |adr[ADDR_W-1:TOP];
  end else begin : g_no_oor
    assign oor = 1'b0;
  end

  // Alignment check, lane mask and store-data placement.
  always_comb begin
    mis     = 1'b0;
    be_base = 8'h01;
    case (size)
      2'b00: begin
        mis     = 1'b0;
        be_base = 8'h01;
      end
      2'b01: begin
        mis     = off[0];
        be_base = 8'h03;
      end
      2'b10: begin
        mis     = |off[1:0];
        be_base = 8'h0F;
      end
      default: begin
        mis     = |off;
        be_base = 8'hFF;
      end
    endcase
    st_be = be_base << off;
    st_wd = datain << {off, 3'b000};
  end

  assign bad = mis | oor;
  assign acc = req & ready;

  // Right-justify the addressed lanes and extend to 64 bits.
  always_comb begin
    rword  = mem[idx];
    lsh    = rword >> {off, 3'b000};
    ld_ext = lsh;
    case (size)
      2'b00:   ld_ext = uns ? {56'd0, lsh[7:0]}  : {{56{lsh[7]}},  lsh[7:0]};
      2'b01:   ld_ext = uns ? {48'd0, lsh[15:0]} : {{48{lsh[15]}}, lsh[15:0]};
      2'b10:   ld_ext = uns ? {32'd0, lsh[31:0]} : {{32{lsh[31]}}, lsh[31:0]};
      default: ld_ext = lsh;
    endcase
  end

  // Single write port shared by the clear sweep and accepted stores.
  always_comb begin
    mem_we  = 1'b0;
    mem_idx = idx;
    mem_be  = st_be;
    mem_wd  = st_wd;
`ifdef DMEM_CLEAR_EN
    if (state == S_CLEAR) begin
      mem_we  = ~rst;
      mem_idx = ptr;
      mem_be  = 8'hFF;
      mem_wd  = 64'd0;
    end else begin
      mem_we  = ~rst & acc & w & ~bad;
    end
`else
    mem_we = ~rst & acc & w & ~bad;
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 8; k++) begin
        if (mem_be[k]) begin
          mem[mem_idx][8*k +: 8] <= mem_wd[8*k +: 8];
        end
      end
    end
  end

  // Control state, load response and error strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready   <= 1'b0;
      rvalid  <= 1'b0;
      err     <= 1'b0;
      dataout <= 64'd0;
`ifdef DMEM_CLEAR_EN
      state   <= S_CLEAR;
      ptr     <= '0;
`endif
    end else begin
      rvalid <= acc & ~w;
      err    <= acc & bad;
      if (acc & ~w) begin
        dataout <= bad ? 64'd0 : ld_ext;
      end
`ifdef DMEM_CLEAR_EN
      case (state)
        S_CLEAR: begin
          ptr <= ptr + IW'(1);
          if (ptr == IW'(DEPTH - 1)) begin
            state <= S_RUN;
            ready <= 1'b1;
          end
        end
        default: begin
          ready <= 1'b1;
        end
      endcase
`else
      ready <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_sized.sv
// Directed-vector bench for dmem_sized; the clear-sweep checks run when DMEM_CLEAR_EN is defined.
module tb_dmem_sized;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 64;

`ifdef DMEM_CLEAR_EN
  localparam int EXP_LAT = DEPTH;
`else
  localparam int EXP_LAT = 1;
`endif

  logic              clk;
  logic              rst;
  logic              req;
  logic              w;
  logic [1:0]        size;
  logic              uns;
  logic [ADDR_W-1:0] adr;
  logic [63:0]       datain;
  logic              ready;
  logic              rvalid;
  logic [63:0]       dataout;
  logic              err;

  int n_vec;
  int n_err;
  int lat;

  dmem_sized #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .w       (w),
    .size    (size),
    .uns     (uns),
    .adr     (adr),
    .datain  (datain),
    .ready   (ready),
    .rvalid  (rvalid),
    .dataout (dataout),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [1:0] sz, input logic u,
                       input logic [63:0] a, input logic [63:0] d);
    req    = 1'b1;
    w      = wr;
    size   = sz;
    uns    = u;
    adr    = a;
    datain = d;
  endtask

  task automatic idle();
    req    = 1'b0;
    w      = 1'b0;
    datain = 64'd0;
  endtask

  // One isolated access; response is sampled during the following cycle.
  task automatic access(input logic wr, input logic [1:0] sz, input logic u,
                        input logic [63:0] a, input logic [63:0] d);
    drive(wr, sz, u, a, d);
    step();
    idle();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < int'(DEPTH) + 20) begin
      step();
      n++;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    idle();
    size = 2'b00;
    uns  = 1'b0;
    adr  = 64'd0;

    // Reset state
    step();
    step();
    chk("rst_ready",   64'(ready),   64'd0);
    chk("rst_rvalid",  64'(rvalid),  64'd0);
    chk("rst_err",     64'(err),     64'd0);
    chk("rst_dataout", dataout,      64'd0);
    rst = 1'b0;
    wait_ready(lat);
    chk("ready_latency", 64'(lat), 64'(EXP_LAT));

    // Double store / load round trip
    access(1'b1, 2'b11, 1'b0, 64'h10, 64'h8877665544332211);
    chk("st_d_rvalid", 64'(rvalid), 64'd0);
    chk("st_d_err",    64'(err),    64'd0);
    access(1'b0, 2'b11, 1'b0, 64'h10, 64'd0);
    chk("ld_d_rvalid", 64'(rvalid), 64'd1);
    chk("ld_d_err",    64'(err),    64'd0);
    chk("ld_d_data",   dataout,     64'h8877665544332211);

    // Byte store ignores upper datain bits; signed/unsigned byte loads
    access(1'b1, 2'b00, 1'b0, 64'h13, 64'h123456789ABCDEAA);
    access(1'b0, 2'b11, 1'b0, 64'h10, 64'd0);
    chk("st_b_merge", dataout, 64'h88776655AA332211);
    access(1'b0, 2'b00, 1'b0, 64'h13, 64'd0);
    chk("ld_b_sext", dataout, 64'hFFFFFFFFFFFFFFAA);
    access(1'b0, 2'b00, 1'b1, 64'h13, 64'd0);
    chk("ld_b_zext", dataout, 64'h00000000000000AA);

    // Half and word loads at upper lanes
    access(1'b0, 2'b01, 1'b0, 64'h16, 64'd0);
    chk("ld_h_sext", dataout, 64'hFFFFFFFFFFFF8877);
    access(1'b0, 2'b10, 1'b1, 64'h14, 64'd0);
    chk("ld_w_zext", dataout, 64'h0000000088776655);
    access(1'b0, 2'b10, 1'b0, 64'h14, 64'd0);
    chk("ld_w_sext", dataout, 64'hFFFFFFFF88776655);
    access(1'b1, 2'b01, 1'b0, 64'h12, 64'hFFFFFFFFFFFF1234);
    access(1'b0, 2'b11, 1'b0, 64'h10, 64'd0);
    chk("st_h_merge", dataout, 64'h8877665512342211);

    // Misaligned accesses
    access(1'b0, 2'b01, 1'b0, 64'h11, 64'd0);
    chk("mis_ld_err",    64'(err),    64'd1);
    chk("mis_ld_rvalid", 64'(rvalid), 64'd1);
    chk("mis_ld_data",   dataout,     64'd0);
    access(1'b1, 2'b10, 1'b0, 64'h16, 64'hDEADBEEFCAFEF00D);
    chk("mis_st_err",    64'(err),    64'd1);
    chk("mis_st_rvalid", 64'(rvalid), 64'd0);
    access(1'b0, 2'b11, 1'b0, 64'h10, 64'd0);
    chk("mis_st_nowrite", dataout, 64'h8877665512342211);
    chk("ok_after_err",   64'(err), 64'd0);

    // Out-of-range accesses
    access(1'b1, 2'b11, 1'b0, 64'h0, 64'h0123456789ABCDEF);
    access(1'b0, 2'b11, 1'b0, 64'h800, 64'd0);
    chk("oor_ld_err",    64'(err),    64'd1);
    chk("oor_ld_rvalid", 64'(rvalid), 64'd1);
    chk("oor_ld_data",   dataout,     64'd0);
    access(1'b1, 2'b11, 1'b0, 64'h800, 64'h00000000DEADDEAD);
    chk("oor_st_err", 64'(err), 64'd1);
    access(1'b0, 2'b11, 1'b0, 64'h0, 64'd0);
    chk("oor_st_nowrite", dataout, 64'h0123456789ABCDEF);

    // Read-after-write with zero gap
    drive(1'b1, 2'b11, 1'b0, 64'h20, 64'h5);
    step();
    chk("raw_st_rvalid", 64'(rvalid), 64'd0);
    drive(1'b0, 2'b11, 1'b0, 64'h20, 64'd0);
    step();
    idle();
    chk("raw_rvalid", 64'(rvalid), 64'd1);
    chk("raw_data",   dataout,     64'h5);

    // Four back-to-back loads
    drive(1'b0, 2'b11, 1'b0, 64'h10, 64'd0);
    step();
    chk("b2b0_rvalid", 64'(rvalid), 64'd1);
    chk("b2b0_data",   dataout,     64'h8877665512342211);
    drive(1'b0, 2'b11, 1'b0, 64'h20, 64'd0);
    step();
    chk("b2b1_rvalid", 64'(rvalid), 64'd1);
    chk("b2b1_data",   dataout,     64'h5);
    drive(1'b0, 2'b11, 1'b0, 64'h00, 64'd0);
    step();
    chk("b2b2_rvalid", 64'(rvalid), 64'd1);
    chk("b2b2_data",   dataout,     64'h0123456789ABCDEF);
    drive(1'b0, 2'b10, 1'b1, 64'h04, 64'd0);
    step();
    idle();
    chk("b2b3_rvalid", 64'(rvalid), 64'd1);
    chk("b2b3_data",   dataout,     64'h0000000001234567);
    step();
    chk("b2b_end_rvalid", 64'(rvalid), 64'd0);
    chk("hold_data",      dataout,     64'h0000000001234567);

    // Reset on the same edge as a store or load
    rst = 1'b1;
    drive(1'b1, 2'b11, 1'b0, 64'h20, 64'h77);
    step();
    chk("rst_st_err",   64'(err),   64'd0);
    chk("rst_st_ready", 64'(ready), 64'd0);
    drive(1'b0, 2'b11, 1'b0, 64'h20, 64'd0);
    step();
    idle();
    chk("rst_ld_rvalid", 64'(rvalid), 64'd0);
    rst = 1'b0;
    wait_ready(lat);
    chk("rerst_latency", 64'(lat), 64'(EXP_LAT));
    access(1'b0, 2'b11, 1'b0, 64'h20, 64'd0);
`ifdef DMEM_CLEAR_EN
    chk("rst_st_dropped", dataout, 64'h0);
`else
    chk("rst_st_dropped", dataout, 64'h5);
`endif

`ifdef DMEM_CLEAR_EN
    // Full sweep clears every word
    access(1'b1, 2'b11, 1'b0, 64'h7F8, 64'hFFFFFFFFFFFFFFFF);
    access(1'b1, 2'b11, 1'b0, 64'h320, 64'hA5A5A5A5A5A5A5A5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready(lat);
    chk("clr_latency", 64'(lat), 64'(DEPTH));
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive(1'b0, 2'b11, 1'b0, 64'(i) << 3, 64'd0);
      step();
      chk("clr_word", dataout, 64'd0);
    end
    idle();

    // Reset mid-sweep restarts the pointer
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) step();
    chk("mid_sweep_ready", 64'(ready), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready(lat);
    chk("restart_latency", 64'(lat), 64'(DEPTH));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_sized.md
# dmem_sized

Parametrised single-port 64-bit data memory with sized, byte-addressed loads and stores, lane-masked writes, and sign/zero-extended loads. Reads are registered with a valid strobe. Misaligned and out-of-range accesses are detected and flagged. It serves as the load/store data store behind the datapath's memory stage, replacing the fixed 256×64 word-addressed memory with combinational read.

## Interface
- `DEPTH`, 256: number of 64-bit words; power of two, ≥ 2.
- `ADDR_W`, 64: width of the byte address `adr`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: access request; accepted on a rising edge where `req & ready`.
- `w` in 1: 1 = store, 0 = load; sampled with `req`.
- `size` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = double.
- `uns` in 1: loads only. 1 = zero-extend, 0 = sign-extend.
- `adr` in `ADDR_W`: byte address.
  - Word index = `adr[log2(DEPTH)+2:3]`.
  - Lane offset = `adr[2:0]`.
- `datain` in 64: store data, right-justified; only the low 8·2^size bits are used.
- `ready` out 1: block can accept a request.
- `rvalid` out 1: one-cycle pulse; load result on `dataout`.
- `dataout` out 64: extended load result; holds its value until the next `rvalid`.
- `err` out 1: one-cycle pulse; the request accepted on the previous edge was rejected.

## Operation
- Byte order is little-endian; lane k = bits [8k+7:8k] of a word.
- A store writes only lanes `offset .. offset+2^size-1`, taking `datain` lanes `0 .. 2^size-1`. The other lanes of the word are unchanged.
- A load selects the same lanes, right-justifies them, then sign- or zero-extends to 64 per `uns`. `uns` is ignored for `size`=11.
- Misaligned access: half with `adr[0]`≠0; word with `adr[1:0]`≠0; double with `adr[2:0]`≠0.
- Out-of-range access: any bit of `adr` above bit log2(DEPTH)+2 is nonzero.
- Rejected access (misaligned or out-of-range):
  - No memory write.
  - `err`=1 on the next cycle.
  - A rejected load also gives `rvalid`=1 with `dataout`=0.
- States:
  - CLEAR: only when the clear feature is compiled in; see Configuration. `ready`=0.
  - RUN: `ready`=1; one request accepted per cycle, no back-pressure.
- A request with `ready`=0 is ignored and not queued.

## Timing
- Reset values: `ready`=0, `rvalid`=0, `err`=0, `dataout`=0. Memory contents are not reset by `rst` alone.
- Load latency is 1. A load accepted at edge N gives `rvalid`/`dataout` valid after edge N, i.e. during cycle N+1.
- A store accepted at edge N is visible to a load accepted at edge N+1 (read-after-write with 0 gap).
- Back-to-back loads give one `rvalid` per cycle.
- A store produces no `rvalid`; `err` only if rejected.
- `rst` asserted mid-operation:
  - A pending `rvalid`/`err` is squashed.
  - A store on the same edge as `rst` is not performed.
  - With clear enabled, the sweep restarts at word 0.

## Configuration
- `DMEM_CLEAR_EN` defined:
  - `rst` puts the block in CLEAR with sweep pointer 0.
  - Each edge with `rst`=0 writes 0 to the word at the pointer and increments it.
  - After word DEPTH-1 is written, the block enters RUN and `ready`=1. The first acceptable request is on the edge DEPTH+1 after `rst` falls.
- `DMEM_CLEAR_EN` undefined:
  - No CLEAR state; contents are undefined after power-up.
  - `ready` rises on the first edge with `rst`=0.

## Test plan
- Double store `adr`=0x10, `datain`=0x8877665544332211, then double load `adr`=0x10 -> `rvalid` the next cycle, `dataout`=0x8877665544332211, `err`=0.
- Byte store 0xAA at `adr`=0x13 over that word, then double load 0x10 -> 0x88776655AA332211. Then byte load 0x13 with `uns`=0 -> 0xFFFFFFFFFFFFFFAA; with `uns`=1 -> 0x00000000000000AA.
- Half load at `adr`=0x11 -> `err`=1, `rvalid`=1, `dataout`=0. Word store at 0x16 -> `err`=1 and the memory word is unchanged.
- `DEPTH`=256: load at `adr`=0x800 -> `err`=1, `dataout`=0. Store at 0x800 -> word 0 is not modified.
- Back-to-back: store 0x5 to 0x20 at edge N, load 0x20 at edge N+1 -> `dataout`=0x5 during cycle N+2. Four consecutive loads -> four consecutive `rvalid` pulses.
- With `DMEM_CLEAR_EN`:
  - `rst` pulse -> `ready`=0 for exactly DEPTH cycles, then every word reads 0.
  - Re-assert `rst` mid-sweep at pointer 100 -> the sweep restarts and `ready` stays low a further DEPTH cycles.
